risc_trace_monitor: RTL and testbench

- Parametrised run monitor for the KGP_RISC core's result output (rout).
- Timestamps every change of the observed value against a free-running cycle counter and buffers each change in an internal FIFO.
- A valid/ready port drains the FIFO. Quiescence detection flags end of program run.
- Sits beside the core in system-level benches and FPGA debug builds, replacing ad hoc waveform inspection.

---
 rtl/kgp_trace_pkg.sv | 15 +
 rtl/risc_trace_monitor_if.sv | 15 +
 rtl/trace_fifo.sv | 50 +++++
 rtl/risc_trace_monitor.sv | 120 ++++++++++++
 tb/tb_risc_trace_monitor.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/kgp_trace_pkg.sv
// kgp_trace_pkg: shared states, default widths and sizing helpers for the risc_trace_monitor slice
//   state_t  : monitor FSM encoding (IDLE=0, ARMED=1, RUN=2, DONE=3)
//   entry_w  : width of one trace entry {value, timestamp}
//   ptr_w    : FIFO pointer width for a given depth
package kgp_trace_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_TS_W = 16;
    function automatic int entry_w(input int data_w, input int ts_w);
        return data_w + ts_w;
    endfunction
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/risc_trace_monitor_if.sv
// risc_trace_monitor_if: valid/ready drain port of the trace FIFO
//   rd_valid : head entry present        rd_ready : consumer accepts head
//   rd_data  : head value                rd_ts    : head timestamp
//   master = monitor side, slave = consumer side
interface risc_trace_monitor_if #(
    parameter int DATA_W = kgp_trace_pkg::DEF_DATA_W,
    parameter int TS_W   = kgp_trace_pkg::DEF_TS_W
);
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [TS_W-1:0]   rd_ts;
    modport master (output rd_valid, rd_data, rd_ts, input rd_ready);
    modport slave  (input rd_valid, rd_data, rd_ts, output rd_ready);
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: show-ahead synchronous FIFO with flush
//   clk, reset (async, active-high), flush (clears pointers/count, wins over push/pop)
//   wr_en/wr_data : push request     rd_en : pop request (ignored when empty)
//   rd_data : head entry, zero when empty     full, empty, count (0..DEPTH)
module trace_fifo
    import kgp_trace_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = ptr_w(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [PW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;
    assign empty = (r_cnt == '0);
    assign full = (r_cnt == (PW+1)'(DEPTH));
    assign count = r_cnt;
    assign w_pop = rd_en && !empty;
    // a pop frees the slot, so a push into a full FIFO is accepted in the same cycle
    assign w_push = wr_en && (!full || w_pop);
    assign rd_data = empty ? '0 : r_mem[r_rp];
    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wp] <= wr_data;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
        end else begin
            r_wp <= r_wp + PW'(w_push);
            r_rp <= r_rp + PW'(w_pop);
            r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/risc_trace_monitor.sv
// risc_trace_monitor: timestamps every change of rout into a drainable trace FIFO and flags quiescence
//   clk, reset (async, active-high), start (re-arm pulse), rout (observed bus)
//   rd (risc_trace_monitor_if.master) : valid/ready drain of {value, timestamp}
//   count (FIFO occupancy), overflow (sticky drop), done (state DONE), state (FSM encoding)
//   TRACE_FILTER_EN : adds filter_mask; only masked bits count as a change in RUN
module risc_trace_monitor
    import kgp_trace_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 16,
    parameter int TS_W       = 16,
    parameter int IDLE_LIMIT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DATA_W-1:0]      rout,
`ifdef TRACE_FILTER_EN
    input  logic [DATA_W-1:0]      filter_mask,
`endif
    risc_trace_monitor_if.master   rd,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   done,
    output logic [1:0]             state
);
    localparam int EW = entry_w(DATA_W, TS_W);
    localparam int IW = $clog2(IDLE_LIMIT + 1);
    state_t            r_state;
    state_t            w_next;
    logic [TS_W-1:0]   r_cyc;
    logic [IW-1:0]     r_idle;
    logic [DATA_W-1:0] r_last;
    logic              r_ovf;
    logic [DATA_W-1:0] w_mask;
    logic              w_chg;
    logic              w_push;
    logic [TS_W-1:0]   w_ts;
    logic [EW-1:0]     w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
`ifdef TRACE_FILTER_EN
    assign w_mask = filter_mask;
`else
    assign w_mask = '1;
`endif
    assign w_chg = |((rout ^ r_last) & w_mask);
    assign w_drop = w_push && w_full && !(rd.rd_ready && !w_empty);
    assign rd.rd_valid = !w_empty;
    assign rd.rd_data = w_head[TS_W +: DATA_W];
    assign rd.rd_ts = w_head[TS_W-1:0];
    assign overflow = r_ovf;
    assign done = (r_state == DONE);
    assign state = r_state;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    // start overrides everything, so captures are only issued when it is low
    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        w_ts = r_cyc;
        if (start) w_next = ARMED;
        else begin
            case (r_state)
                ARMED: begin
                    w_push = 1'b1;
                    w_ts = '0;
                    w_next = RUN;
                end
                RUN: begin
                    w_push = w_chg;
                    if (!w_chg && r_idle == IW'(IDLE_LIMIT - 1)) w_next = DONE;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cyc <= '0;
            r_idle <= '0;
            r_last <= '0;
            r_ovf <= 1'b0;
        end else if (start) begin
            r_cyc <= '0;
            r_idle <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf || w_drop;
            case (r_state)
                ARMED: begin
                    r_last <= rout;
                    r_cyc <= TS_W'(1);
                    r_idle <= '0;
                end
                RUN: begin
                    r_cyc <= (&r_cyc) ? r_cyc : r_cyc + 1'b1;
                    r_last <= w_chg ? rout : r_last;
                    r_idle <= w_chg ? '0 : r_idle + 1'b1;
                end
                default: ;
            endcase
        end
    end
    trace_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (start),
        .wr_en   (w_push),
        .wr_data ({rout, w_ts}),
        .rd_en   (rd.rd_ready),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (count)
    );
endmodule

// File: tb/tb_risc_trace_monitor.sv
// tb_risc_trace_monitor: directed bench for risc_trace_monitor (DEPTH=4, IDLE_LIMIT=64); define TRACE_FILTER_EN to cover the mask
module tb_risc_trace_monitor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] rout = '0;
    logic [2:0]  count;
    logic        overflow;
    logic        done;
    logic [1:0]  state;
    int          n_chk = 0;
    int          n_pass = 0;
`ifdef TRACE_FILTER_EN
    logic [15:0] filter_mask = 16'hFFFF;
`endif
    risc_trace_monitor_if #(.DATA_W(16), .TS_W(16)) rd_if ();
    risc_trace_monitor #(.DATA_W(16), .DEPTH(4), .TS_W(16), .IDLE_LIMIT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rout        (rout),
`ifdef TRACE_FILTER_EN
        .filter_mask (filter_mask),
`endif
        .rd          (rd_if),
        .count       (count),
        .overflow    (overflow),
        .done        (done),
        .state       (state)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout required completion");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic pop_chk(input string tag, input logic [15:0] d, input logic [15:0] ts);
        chk({tag, "_valid"}, 32'(rd_if.rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(rd_if.rd_data), 32'(d));
        chk({tag, "_ts"}, 32'(rd_if.rd_ts), 32'(ts));
        rd_if.rd_ready = 1'b1;
        tick();
        rd_if.rd_ready = 1'b0;
    endtask
    initial begin
        rd_if.rd_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valid", 32'(rd_if.rd_valid), 32'd0);
        chk("rst_data", 32'(rd_if.rd_data), 32'd0);
        chk("rst_ts", 32'(rd_if.rd_ts), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        tick();
        chk("idle_hold", 32'(state), 32'd0);
        // baseline capture and quiescence
        pulse_start();
        chk("base_armed", 32'(state), 32'd1);
        tick();
        chk("base_run", 32'(state), 32'd2);
        chk("base_count", 32'(count), 32'd1);
        chk("base_data", 32'(rd_if.rd_data), 32'd0);
        chk("base_ts", 32'(rd_if.rd_ts), 32'd0);
        repeat (63) tick();
        chk("base_not_done", 32'(done), 32'd0);
        tick();
        chk("base_done", 32'(done), 32'd1);
        chk("base_done_state", 32'(state), 32'd3);
        repeat (6) tick();
        chk("base_done_count", 32'(count), 32'd1);
        // change capture
        pulse_start();
        chk("chg_flush", 32'(count), 32'd0);
        chk("chg_done_clr", 32'(done), 32'd0);
        tick();
        repeat (2) tick();
        rout = 16'h0001;
        tick();
        repeat (6) tick();
        rout = 16'h00FF;
        tick();
        chk("chg_count", 32'(count), 32'd3);
        pop_chk("chg0", 16'h0000, 16'd0);
        pop_chk("chg1", 16'h0001, 16'd3);
        pop_chk("chg2", 16'h00FF, 16'd10);
        chk("chg_empty", 32'(rd_if.rd_valid), 32'd0);
        // full with simultaneous pop
        rout = 16'h0000;
        pulse_start();
        tick();
        for (int i = 1; i <= 3; i++) begin
            rout = 16'(i);
            tick();
        end
        chk("fp_full", 32'(count), 32'd4);
        rd_if.rd_ready = 1'b1;
        rout = 16'h00AA;
        tick();
        rd_if.rd_ready = 1'b0;
        chk("fp_count", 32'(count), 32'd4);
        chk("fp_ovf", 32'(overflow), 32'd0);
        pop_chk("fp1", 16'h0001, 16'd1);
        pop_chk("fp2", 16'h0002, 16'd2);
        pop_chk("fp3", 16'h0003, 16'd3);
        pop_chk("fp4", 16'h00AA, 16'd4);
        chk("fp_drained", 32'(count), 32'd0);
        // overflow
        rout = 16'h0000;
        pulse_start();
        tick();
        for (int i = 1; i <= 8; i++) begin
            rout = 16'(i);
            tick();
        end
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        pop_chk("ovf0", 16'h0000, 16'd0);
        pop_chk("ovf1", 16'h0001, 16'd1);
        pop_chk("ovf2", 16'h0002, 16'd2);
        pop_chk("ovf3", 16'h0003, 16'd3);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        pulse_start();
        chk("ovf_clr", 32'(overflow), 32'd0);
        // restart mid-run
        tick();
        rout = 16'd9;
        tick();
        rout = 16'd10;
        tick();
        chk("rs_count3", 32'(count), 32'd3);
        pulse_start();
        chk("rs_flush", 32'(count), 32'd0);
        chk("rs_valid", 32'(rd_if.rd_valid), 32'd0);
        chk("rs_armed", 32'(state), 32'd1);
        tick();
        chk("rs_count1", 32'(count), 32'd1);
        chk("rs_data", 32'(rd_if.rd_data), 32'd10);
        chk("rs_ts", 32'(rd_if.rd_ts), 32'd0);
        // async reset between edges
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ar_state", 32'(state), 32'd0);
        chk("ar_valid", 32'(rd_if.rd_valid), 32'd0);
        chk("ar_data", 32'(rd_if.rd_data), 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
`ifdef TRACE_FILTER_EN
        filter_mask = 16'h00FF;
        rout = 16'h0000;
        pulse_start();
        tick();
        rout = 16'h1200;
        tick();
        rout = 16'h1234;
        tick();
        chk("flt_count", 32'(count), 32'd2);
        pop_chk("flt0", 16'h0000, 16'd0);
        pop_chk("flt1", 16'h1234, 16'd2);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
